// File: rtl/plc_io_port_if.sv
// plc_io_port_if
//   Request/acknowledge data-bus between the PLC core (master) and the
//   I/O port (slave). 4-phase handshake: the master holds req_in until it
//   sees ack_out, then drops req_in; the slave drops ack_out in response.
//
//   req_in    master->slave  bus request
//   we_in     master->slave  1 = write, 0 = read
//   addr_in   master->slave  3-bit register address
//   wdata_in  master->slave  write data, WIDTH bits
//   rdata_out slave->master  read data, valid while ack_out=1
//   ack_out   slave->master  bus acknowledge
interface plc_io_port_if #(
  parameter int WIDTH = 8
);
  logic             req_in;
  logic             we_in;
  logic [2:0]       addr_in;
  logic [WIDTH-1:0] wdata_in;
  logic [WIDTH-1:0] rdata_out;
  logic             ack_out;

  modport master (
    output req_in, we_in, addr_in, wdata_in,
    input  rdata_out, ack_out
  );

  modport slave (
    input  req_in, we_in, addr_in, wdata_in,
    output rdata_out, ack_out
  );
endinterface

// File: rtl/plc_io_port.sv
// plc_io_port
//   Memory-mapped digital I/O responder. Drives PLC output pins from the OUT
//   latch, samples PLC input pins through a 2-flop synchroniser and a
//   per-bit debouncer, records debounced edges in sticky RISE/FALL flags and
//   raises an interrupt for enabled flags.
//
//   clk_in    system clock, rising edge
//   rst_in    asynchronous reset, active-high
//   bus       plc_io_port_if slave: req/we/addr/wdata in, rdata/ack out
//   pins_in   raw asynchronous PLC inputs
//   pins_out  PLC outputs (= OUT register)
//   irq_out   |((RISE | FALL) & IEN)
//
//   Register map: 0 OUT rw, 1 IN ro, 2 RISE r/w1c, 3 FALL r/w1c, 4 IEN rw,
//   5 STATUS ro (bit0 = irq_out), 6/7 read 0.
module plc_io_port #(
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  plc_io_port_if.slave     bus,
  input  logic [WIDTH-1:0] pins_in,
  output logic [WIDTH-1:0] pins_out,
  output logic             irq_out
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DB_LIMIT = CW'(DEBOUNCE);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] ien_q, ien_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] rd_mux;
  logic             wr_en;

  // ---------------------------------------------------------------------
  // Input path: per-bit debounce counter. The counter only runs while the
  // synchronised value disagrees with the accepted one; any return to
  // agreement restarts it, which is what rejects short glitches.
  // ---------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_deb
      logic [CW-1:0] cnt_q, cnt_d;
      logic [CW-1:0] cnt_inc;
      logic          differ;
      logic          accept;

      assign differ       = sync2_q[gi] ^ stable_q[gi];
      assign cnt_inc      = cnt_q + 1'b1;
      assign accept       = differ && (cnt_inc == DB_LIMIT);
      assign cnt_d        = (differ && !accept) ? cnt_inc : '0;
      assign stable_d[gi] = accept ? sync2_q[gi] : stable_q[gi];

      always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end
    end
  endgenerate

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
    end else begin
      sync1_q  <= pins_in;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
    end
  end

  // ---------------------------------------------------------------------
  // Read mux (full 3-bit decode)
  // ---------------------------------------------------------------------
  always_comb begin
    rd_mux = '0;
    case (bus.addr_in)
      3'd0: rd_mux = out_q;
      3'd1: rd_mux = stable_q;
      3'd2: rd_mux = rise_q;
      3'd3: rd_mux = fall_q;
      3'd4: rd_mux = ien_q;
      3'd5: rd_mux[0] = irq_out;
      default: rd_mux = '0;
    endcase
  end

  // ---------------------------------------------------------------------
  // Handshake FSM. The access happens once, on the IDLE->ACK edge; ACK
  // just waits for the core to drop its request.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_in) begin
          state_d = ACK;
          wr_en   = bus.we_in;
          rdata_d = bus.we_in ? '0 : rd_mux;
        end
      end
      ACK: begin
        if (!bus.req_in) begin
          state_d = IDLE;
          rdata_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        rdata_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Register writes. A W1C clear and a new edge on the same bit in the
  // same cycle resolve in favour of the edge, so no event is lost.
  // ---------------------------------------------------------------------
  always_comb begin
    logic [WIDTH-1:0] w1c_rise;
    logic [WIDTH-1:0] w1c_fall;
    w1c_rise = '0;
    w1c_fall = '0;
    out_d    = out_q;
    ien_d    = ien_q;
    if (wr_en) begin
      case (bus.addr_in)
        3'd0: out_d    = bus.wdata_in;
        3'd2: w1c_rise = bus.wdata_in;
        3'd3: w1c_fall = bus.wdata_in;
        3'd4: ien_d    = bus.wdata_in;
        default: ;
      endcase
    end
    rise_d = (rise_q & ~w1c_rise) | (stable_d & ~stable_q);
    fall_d = (fall_q & ~w1c_fall) | (~stable_d & stable_q);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      rdata_q <= '0;
      out_q   <= '0;
      ien_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      out_q   <= out_d;
      ien_q   <= ien_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign bus.ack_out   = (state_q == ACK);
  assign bus.rdata_out = rdata_q;
  assign pins_out      = out_q;
  assign irq_out       = |((rise_q | fall_q) & ien_q);

endmodule

// File: tb/tb_plc_io_port.sv
module tb_plc_io_port;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pins_in = 8'h00;
  logic [7:0] pins_out;
  logic       irq;

  int vectors = 0;
  int errors  = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  plc_io_port_if #(.WIDTH(8)) bus ();

  plc_io_port #(.WIDTH(8), .DEBOUNCE(4)) dut (
    .clk_in  (clk),
    .rst_in  (rst),
    .bus     (bus),
    .pins_in (pins_in),
    .pins_out(pins_out),
    .irq_out (irq)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete 4-phase transaction. Reads push their expected data into
  // the scoreboard; it is popped when ack_out is seen.
  task automatic bus_xfer(input logic we, input logic [2:0] addr,
                          input logic [7:0] wdata, input logic [7:0] exp,
                          input string tag);
    int n;
    logic [7:0] e;
    @(negedge clk);
    bus.req_in   = 1'b1;
    bus.we_in    = we;
    bus.addr_in  = addr;
    bus.wdata_in = wdata;
    if (!we) sb.push_back(exp);
    @(posedge clk); #1;
    chk({tag, "_ack_latency"}, {7'b0, bus.ack_out}, 8'h01);
    n = 0;
    while (!bus.ack_out && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (!we && sb.size() > 0) begin
      e = sb.pop_front();
      chk(tag, bus.rdata_out, e);
    end
    // hold the request one extra cycle: ack must stay, access not repeated
    @(posedge clk); #1;
    chk({tag, "_ack_hold"}, {7'b0, bus.ack_out}, 8'h01);
    @(negedge clk);
    bus.req_in = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_ack_drop"}, {7'b0, bus.ack_out}, 8'h00);
    chk({tag, "_rdata_zero"}, bus.rdata_out, 8'h00);
    $display("xfer %-12s we=%0d addr=%0d wdata=%h exp=%h", tag, we, addr, wdata, exp);
  endtask

  initial begin
    bus.req_in   = 1'b0;
    bus.we_in    = 1'b0;
    bus.addr_in  = 3'd0;
    bus.wdata_in = 8'h00;

    // 1: reset state and a read of IN
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {7'b0, bus.ack_out}, 8'h00);
    chk("rst_rdata", bus.rdata_out, 8'h00);
    chk("rst_pins_out", pins_out, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    bus_xfer(1'b0, 3'd1, 8'h00, 8'h00, "rd_in0");

    // 2: OUT register, unused and read-only addresses
    bus_xfer(1'b1, 3'd0, 8'hA5, 8'h00, "wr_out");
    chk("pins_out_a5", pins_out, 8'hA5);
    bus_xfer(1'b0, 3'd0, 8'h00, 8'hA5, "rd_out");
    bus_xfer(1'b1, 3'd7, 8'hFF, 8'h00, "wr_a7");
    bus_xfer(1'b0, 3'd7, 8'h00, 8'h00, "rd_a7");
    bus_xfer(1'b1, 3'd1, 8'hFF, 8'h00, "wr_in");
    bus_xfer(1'b0, 3'd1, 8'h00, 8'h00, "rd_in_ro");

    // 3: debounce timing, observed through irq_out with IEN bit0 set
    bus_xfer(1'b1, 3'd4, 8'h01, 8'h00, "wr_ien1");
    @(negedge clk);
    pins_in = 8'h01;
    repeat (5) @(posedge clk);
    #1;
    chk("deb_not_yet", {7'b0, irq}, 8'h00);
    @(posedge clk); #1;
    chk("deb_accept", {7'b0, irq}, 8'h01);
    // 3-cycle glitch on bit1 must be rejected
    @(negedge clk);
    pins_in = 8'h03;
    repeat (3) @(negedge clk);
    pins_in = 8'h01;
    repeat (10) @(posedge clk);
    bus_xfer(1'b0, 3'd1, 8'h00, 8'h01, "rd_in1");
    bus_xfer(1'b0, 3'd2, 8'h00, 8'h01, "rd_rise1");
    bus_xfer(1'b0, 3'd3, 8'h00, 8'h00, "rd_fall0");

    // 4: interrupt, STATUS and flag / enable clearing
    bus_xfer(1'b0, 3'd5, 8'h00, 8'h01, "rd_status1");
    bus_xfer(1'b1, 3'd2, 8'h01, 8'h00, "w1c_rise");
    chk("irq_after_w1c", {7'b0, irq}, 8'h00);
    bus_xfer(1'b0, 3'd2, 8'h00, 8'h00, "rd_rise_clr");
    @(negedge clk);
    pins_in = 8'h00;
    repeat (10) @(posedge clk);
    #1;
    chk("irq_fall", {7'b0, irq}, 8'h01);
    bus_xfer(1'b1, 3'd4, 8'h00, 8'h00, "wr_ien0");
    chk("irq_ien_off", {7'b0, irq}, 8'h00);
    bus_xfer(1'b0, 3'd3, 8'h00, 8'h01, "rd_fall1");
    bus_xfer(1'b0, 3'd5, 8'h00, 8'h00, "rd_status0");

    // 5: W1C of RISE[0] sampled on the same edge that sets RISE[0]
    @(negedge clk);
    pins_in = 8'h01;
    repeat (4) @(negedge clk);
    bus_xfer(1'b1, 3'd2, 8'h01, 8'h00, "w1c_race");
    bus_xfer(1'b0, 3'd2, 8'h00, 8'h01, "rd_rise_set");
    bus_xfer(1'b1, 3'd3, 8'h01, 8'h00, "w1c_fall");
    bus_xfer(1'b0, 3'd3, 8'h00, 8'h00, "rd_fall_clr");

    // 6: reset while in ACK
    bus_xfer(1'b1, 3'd4, 8'h01, 8'h00, "wr_ien_b");
    chk("irq_pre_rst", {7'b0, irq}, 8'h01);
    pins_in = 8'h00;
    @(negedge clk);
    bus.req_in  = 1'b1;
    bus.we_in   = 1'b0;
    bus.addr_in = 3'd0;
    @(posedge clk); #1;
    chk("mid_ack", {7'b0, bus.ack_out}, 8'h01);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_ack", {7'b0, bus.ack_out}, 8'h00);
    chk("rst_mid_pins", pins_out, 8'h00);
    chk("rst_mid_irq", {7'b0, irq}, 8'h00);
    chk("rst_mid_rdata", bus.rdata_out, 8'h00);
    @(negedge clk);
    bus.req_in = 1'b0;
    rst = 1'b0;
    bus_xfer(1'b0, 3'd0, 8'h00, 8'h00, "rd_out_rst");
    bus_xfer(1'b0, 3'd4, 8'h00, 8'h00, "rd_ien_rst");
    bus_xfer(1'b1, 3'd0, 8'h3C, 8'h00, "wr_out2");
    chk("pins_out_3c", pins_out, 8'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/plc_io_port.md
Name: plc_io_port

Overview:
Memory-mapped digital I/O responder for the PLC processor. It is the target side of the processor's data-bus request/acknowledge handshake: the core initiates reads and writes, and this block answers them. It drives the PLC output pins from a latch, and it samples the PLC input pins through a synchroniser and a debouncer. It records rising and falling input edges in sticky flags and raises an interrupt request to the core.

Parameters:
WIDTH, 8, number of I/O pins; also the bus data width (1..8).
DEBOUNCE, 4, consecutive cycles a synchronised input must differ from its stable value before the change is accepted (>=1).

Ports:
clk_in  input  1  system clock; all state updates on the rising edge.
rst_in  input  1  asynchronous reset, active-high.
req_in  input  1  bus request from the core; held high until ack_out is seen.
we_in  input  1  1 = write, 0 = read; valid while req_in=1.
addr_in  input  3  register address.
wdata_in  input  WIDTH  write data.
rdata_out  output  WIDTH  read data; valid while ack_out=1.
ack_out  output  1  bus acknowledge.
pins_in  input  WIDTH  raw asynchronous PLC inputs.
pins_out  output  WIDTH  PLC outputs.
irq_out  output  1  interrupt request to the core.

Behaviour:
- Reset (asynchronous, immediate):
  - OUT, IEN, RISE, FALL, stable inputs, both sync stages and debounce counters all clear to 0.
  - FSM goes to IDLE; ack_out=0, rdata_out=0, pins_out=0, irq_out=0.
  - Reset asserted mid-transaction drops ack_out at once. The core must re-issue the request.
- Register map:
  - 0 OUT: read/write.
  - 1 IN: read-only, debounced stable value.
  - 2 RISE: read, write-1-to-clear.
  - 3 FALL: read, write-1-to-clear.
  - 4 IEN: read/write, interrupt enable per bit.
  - 5 STATUS: read-only; bit0 = irq_out, other bits 0.
  - 6, 7: read 0, writes ignored, acknowledged normally.
  - Writes to read-only addresses are ignored.
- Handshake FSM (4-phase):
  - IDLE: on a clock edge with req_in=1, latch the access. A write updates the target register at that edge. A read loads rdata_out at that edge. Go to ACK.
  - ACK: ack_out=1 (registered, = state==ACK). Stay while req_in=1; the access is not repeated. At the edge where req_in=0, go to IDLE; ack_out falls and rdata_out returns to 0.
  - Latency: ack_out is high one cycle after req_in is sampled. The minimum transaction is 2 cycles.
- Input path, per bit:
  - 2-flop synchroniser, giving sync2.
  - A counter increments while sync2 != stable and resets to 0 when they are equal.
  - At the edge where the counter would reach DEBOUNCE, stable takes sync2 and the counter clears.
  - A clean pin change appears in IN 2+DEBOUNCE edges after it is first sampled. Glitches shorter than DEBOUNCE cycles (after sync) are rejected.
- Edge flags:
  - On the edge where stable goes 0->1, set RISE[i]; 1->0 sets FALL[i]. Flags are sticky.
  - If a W1C clear and a set hit the same bit on the same edge, the set wins.
  - Pins held high through reset release produce a RISE after debounce; this is intended and is the power-up snapshot.
- Outputs:
  - pins_out = OUT, registered, updating the edge after the write is sampled.
  - irq_out = |((RISE | FALL) & IEN), combinational from registers. It clears when the flags or the enable clear.
- Address and width rules:
  - Addresses are decoded in full (3 bits).
  - wdata bits above WIDTH do not exist. Unused STATUS bits read 0.

Test Plan:
1. Reset then read IN with pins_in=0 -> ack_out high 1 cycle after req_in, rdata_out=0x00; ack_out drops the cycle after req_in falls.
2. Write 0xA5 to OUT, then read addr 0 -> pins_out=0xA5 after the write edge, rdata_out=0xA5; read addr 7 -> 0x00, ack still given.
3. DEBOUNCE=4, pins_in goes 0x00->0x01 and is held -> IN=0x01 exactly 6 edges after the first sample, RISE=0x01; a 3-cycle pulse on bit1 -> IN and FALL unchanged.
4. IEN=0x01, bit0 rises -> irq_out=1 and STATUS=0x01; write 0x01 to RISE -> irq_out=0; write 0x00 to IEN with FALL pending -> irq_out stays 0.
5. W1C of RISE bit0 on the same edge as a new rising edge on bit0 -> RISE bit0 remains 1.
6. Assert rst_in while in ACK with req_in high -> ack_out, pins_out and irq_out go 0 immediately; after release, a new request completes normally.
